key_conditioner: RTL and testbench

//  Conditions raw board pushbuttons before they reach the Nios system keys_export PIO input.
//  Per key: 2-flop synchronizer, then a debounce FSM, then a clean active-high level.

---
 rtl/key_cond_pkg.sv | 24 ++
 rtl/key_debounce_fsm.sv | 153 +++++++++++++++
 rtl/key_conditioner.sv | 39 +++
 tb/tb_key_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types, default 50 MHz timing and counter sizing for the pushbutton conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kstate_t;

  localparam int DEF_DEBOUNCE_CYCLES      = 500_000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 25_000_000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 5_000_000;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One pushbutton: 2-flop synchronizer, debounce FSM, registered level and press/release/repeat strobes.
module key_debounce_fsm
  import key_cond_pkg::*;
#(
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN            = 1,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam logic IDLE_LVL = (KEY_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_cycles
    $error("key_debounce_fsm: every *_CYCLES parameter must be >= 1");
  end

  logic          sync1, sync2, p;
  kstate_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          level_nxt, press_nxt, release_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign p       = sync2 ^ IDLE_LVL;
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      RELEASED: begin
        cnt_nxt = '0;
        if (p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!p) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      cnt         <= '0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      level       <= level_nxt;
      press_stb   <= press_nxt;
      release_stb <= release_nxt;
    end
  end

  // The repeat counter only advances while the key stays HELD; in RELEASE_WAIT it keeps its value.
  if (REPEAT_EN != 0) begin : g_rpt
    localparam logic [CW-1:0] DLY_MAX = CW'(REPEAT_DELAY_CYCLES);
    localparam logic [CW-1:0] PER_MAX = CW'(REPEAT_PERIOD_CYCLES);

    logic [CW-1:0] rpt_cnt, rpt_inc, rpt_target;
    logic          rpt_first;

    assign rpt_inc    = (rpt_cnt == {CW{1'b1}}) ? rpt_cnt : rpt_cnt + CNT_ONE;
    assign rpt_target = rpt_first ? DLY_MAX : PER_MAX;

    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_cnt    <= '0;
        rpt_first  <= 1'b0;
        repeat_stb <= 1'b0;
      end else begin
        repeat_stb <= 1'b0;
        if (press_nxt) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b1;
        end else if (state == HELD && p) begin
          if (rpt_inc == rpt_target) begin
            repeat_stb <= 1'b1;
            rpt_cnt    <= '0;
            rpt_first  <= 1'b0;
          end else begin
            rpt_cnt <= rpt_inc;
          end
        end
      end
    end
  end else begin : g_no_rpt
    assign repeat_stb = 1'b0;
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw pushbuttons into clean levels and strobes for the Nios keys_export PIO.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS             = 3,
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN            = 1,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .KEY_ACTIVE_LOW      (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_EN           (REPEAT_EN),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_key (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .raw        (key_raw[i]),
      .level      (keys_out[i]),
      .press_stb  (key_press[i]),
      .release_stb(key_release[i]),
      .repeat_stb (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench: dut_a is active-low with repeat, dut_b is active-high with repeat disabled.
module tb_key_conditioner;

  localparam int DEB = 8;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw_a, raw_b;
  logic [2:0] keys_out_a, key_press_a, key_release_a, key_repeat_a;
  logic [2:0] keys_out_b, key_press_b, key_release_b, key_repeat_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS(3), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(32), .REPEAT_PERIOD_CYCLES(8)
  ) u_dut_a (
    .clk_clk(clk), .reset_reset(rst), .key_raw(raw_a), .keys_out(keys_out_a),
    .key_press(key_press_a), .key_release(key_release_a), .key_repeat(key_repeat_a)
  );

  key_conditioner #(
    .NUM_KEYS(3), .KEY_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(32), .REPEAT_PERIOD_CYCLES(8)
  ) u_dut_b (
    .clk_clk(clk), .reset_reset(rst), .key_raw(raw_b), .keys_out(keys_out_b),
    .key_press(key_press_b), .key_release(key_release_b), .key_repeat(key_repeat_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " keys_out_a"}, 32'(keys_out_a), 0);
    check({tag, " press_a"},    32'(key_press_a), 0);
    check({tag, " release_a"},  32'(key_release_a), 0);
    check({tag, " repeat_a"},   32'(key_repeat_a), 0);
    check({tag, " keys_out_b"}, 32'(keys_out_b), 0);
  endtask

  // Change one key's pin to the pressed/released level and follow it for n edges (edge 0 first).
  task automatic run_edge(input bit sel, input int idx, input bit press_now, input int n, input bit chk_rpt);
    if (sel) raw_b[idx] = press_now;
    else     raw_a[idx] = !press_now;
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("lvl d%0d k%0d e%0d", sel, idx, k),
            32'(sel ? keys_out_b[idx] : keys_out_a[idx]), 32'(press_now ? (k >= LAT) : (k < LAT)));
      check($sformatf("press d%0d k%0d e%0d", sel, idx, k),
            32'(sel ? key_press_b[idx] : key_press_a[idx]), 32'(press_now && k == LAT));
      check($sformatf("release d%0d k%0d e%0d", sel, idx, k),
            32'(sel ? key_release_b[idx] : key_release_a[idx]), 32'(!press_now && k == LAT));
      if (chk_rpt)
        check($sformatf("repeat d%0d k%0d e%0d", sel, idx, k),
              32'(sel ? key_repeat_b[idx] : key_repeat_a[idx]), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    raw_a = 3'b111;
    raw_b = 3'b000;
    repeat (3) tick();
    check_all_zero("in_reset");
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Clean press and release on key 0
    run_edge(0, 0, 1'b1, 100, 1'b0);
    run_edge(0, 0, 1'b0, 100, 1'b1);

    // Bounce on key 1 with no stable run of DEB samples
    for (int k = 0; k < 40; k++) begin
      raw_a[1] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("bounce lvl e%0d", k), 32'(keys_out_a[1]), 0);
      check($sformatf("bounce press e%0d", k), 32'(key_press_a[1]), 0);
    end
    raw_a[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("settle lvl e%0d", k), 32'(keys_out_a[1]), 0);
      check($sformatf("settle press e%0d", k), 32'(key_press_a[1]), 0);
    end

    // Short release glitch while held on key 1
    run_edge(0, 1, 1'b1, 11, 1'b0);
    raw_a[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) raw_a[1] = 1'b0;
      tick();
      check($sformatf("glitch lvl e%0d", k), 32'(keys_out_a[1]), 1);
      check($sformatf("glitch release e%0d", k), 32'(key_release_a[1]), 0);
    end
    run_edge(0, 1, 1'b0, 20, 1'b0);

    // Auto-repeat on key 2: strobes at +32 then every 8 up to +80
    run_edge(0, 2, 1'b1, 11, 1'b1);
    for (int t = 32; t <= 80; t += 8) exp_q.push_back(32'(t));
    for (int k = 1; k <= 80; k++) begin
      logic exp_bit;
      tick();
      exp_bit = (exp_q.size() > 0 && exp_q[0] == 32'(k));
      if (exp_bit) void'(exp_q.pop_front());
      check($sformatf("repeat +%0d", k), 32'(key_repeat_a[2]), 32'(exp_bit));
      check($sformatf("repeat lvl +%0d", k), 32'(keys_out_a[2]), 1);
    end
    check("repeat count", 32'(exp_q.size()), 0);
    run_edge(0, 2, 1'b0, 20, 1'b1);

    // Simultaneous press of all keys, key 0 released alone at +20
    raw_a = 3'b000;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      check($sformatf("simul press e%0d", k), 32'(key_press_a), (k == LAT) ? 32'h7 : 32'h0);
    end
    repeat (20) tick();
    check("simul held", 32'(keys_out_a), 32'h7);
    raw_a[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("simul rel0 e%0d", k), 32'(key_release_a), (k == LAT) ? 32'h1 : 32'h0);
      check($sformatf("simul lvl e%0d", k), 32'(keys_out_a), (k >= LAT) ? 32'h6 : 32'h7);
    end
    raw_a = 3'b111;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("simul rel12 e%0d", k), 32'(key_release_a), (k == LAT) ? 32'h6 : 32'h0);
    end

    // Reset in the middle of a hold
    run_edge(0, 0, 1'b1, 11, 1'b0);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid_hold_reset");
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("rearm press e%0d", k), 32'(key_press_a[0]), 32'(k == LAT + 1));
      check($sformatf("rearm release e%0d", k), 32'(key_release_a[0]), 0);
      check($sformatf("rearm lvl e%0d", k), 32'(keys_out_a[0]), 32'(k >= LAT + 1));
    end
    run_edge(0, 0, 1'b0, 15, 1'b1);

    // Active-high pins, repeat disabled
    run_edge(1, 0, 1'b1, 100, 1'b1);
    run_edge(1, 0, 1'b0, 20, 1'b1);
    run_edge(1, 2, 1'b1, 11, 1'b1);
    for (int k = 1; k <= 80; k++) begin
      tick();
      check($sformatf("b repeat +%0d", k), 32'(key_repeat_b), 0);
      check($sformatf("b lvl +%0d", k), 32'(keys_out_b[2]), 1);
    end
    run_edge(1, 2, 1'b0, 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
